filter_conv3x3: RTL
===================

# filter_conv3x3

Per-channel 3×3 convolution stage that consumes the zero-padded RGB stream produced by the demosaic/boundary-insertion stage and feeds the rgb2ycc matrix multiplier. It buffers two padded rows in a linear delay line, forms a 3×3 window per colour channel, applies a signed 9-tap kernel, and emits exactly `width*height` filtered pixels per frame in raster order. It fills the `filter_fifo` slot in `processing`.

## Interface
- `width`, 320, active pixels per row (W).
- `height`, 240, active rows per frame (H).
- `COEF`, {8'sd1,8'sd2,8'sd1, 8'sd2,8'sd4,8'sd2, 8'sd1,8'sd2,8'sd1}, packed 72-bit; tap k (0 = top-left, row-major, 8 = bottom-right) at `COEF[71-8k -: 8]`, signed.
- `SHIFT`, 4, arithmetic right shift applied to each channel's sum.
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `newFrame`  in  1  restarts frame counters.
- `iValid`  in  1  `iData` valid this cycle.
- `iData`  in  24  padded input pixel, {R,G,B}, unsigned 8 bits each.
- `oValid`  out  1  `oData` valid.
- `oData`  out  24  filtered {R,G,B}.
- `oDone`  out  1  one-cycle pulse with the last pixel of a frame.

## Operation
- Input frame format: (H+2) padded rows × W1 = W+1 samples, raster order; padded rows 0 and H+1 are zeros; column W of each row is zero (serves as right pad of its row and left pad of the next).
- Delay line: 2·W1+3 taps × 24 bits; shifts only on `iValid`. Window = taps {n-2W1-2..n-2W1}, {n-W1-2..n-W1}, {n-2..n}; centre = n-W1-1.
- Counters `colIn` (0..W), `rowIn` (0..H+1) give the position of the sample accepted. Wrap: colIn==W → 0, rowIn+1; after (H+1, W) both return to 0.
- Centre valid iff `colIn` in 1..W and `rowIn` in 2..H+1 (centre = (rowIn-1, colIn-1) in padded coords). Other accepted samples produce no output.
- Per channel: product = {1'b0,pixel} × coef (17-bit signed); sum of 9 products (21-bit signed); `>>> SHIFT`; result per Configuration.
- Output counter `oCnt` 0..W·H-1 increments on `oValid`; `oDone` = `oValid` && `oCnt` == W·H-1; `oCnt` then returns to 0.
- `newFrame`: `colIn`, `rowIn`, `oCnt` ← 0; delay line and in-flight pipeline unaffected. `newFrame` with `iValid` in the same cycle: sample is index 0 of the new frame.
- No backpressure: downstream must accept every `oValid` cycle.

## Timing
- Reset: `oValid`=0, `oData`=0, `oDone`=0; delay line, pipeline registers, all counters cleared.
- Pipeline: edge k captures sample into delay line with valid-centre tag; k+1 products registered; k+2 sums registered; k+3 shift/clip registered → `oData`/`oValid`/`oDone` update at edge k+3. Fixed latency 3 edges after capture.
- Pipeline stages advance every cycle regardless of `iValid`; input gaps produce output gaps of equal spacing, never data changes.
- First output of a frame: from sample index 2·W1+1 (rowIn=2, colIn=1).
- Reset mid-frame: everything in flight discarded; next accepted sample is index 0.
- Back-to-back frames with no gap are supported; previous frame's stale taps are always pad zeros for well-formed input.

## Configuration
- `FILTER_CONV3X3_SAT_EN` defined: each shifted sum clipped to [0,255].
- Not defined: each channel output = bits [7:0] of the shifted sum (two's-complement wrap).

## Test plan
- W=4, H=3, all active pixels 100, default COEF → interior (1,1),(1,2) = 100; corner (0,0) = 56; top edge (0,1) = 75; left edge (1,0) = 75.
- Impulse: R=255 at active (1,1), else 0 → R out (1,1)=63, (0,1)=31, (0,0)=15, (2,3)=0; G,B all 0.
- COEF centre 127 else 0, SHIFT 0, all inputs 10 → 255 with macro, 246 without; centre −1 → 0 with macro, 246 without.
- Same frame with `iValid` high every other cycle → identical oData sequence, exactly 12 `oValid`, `oDone` on 12th; first `oValid` 3 edges after capture of index 11.
- Two back-to-back frames (`newFrame` with first sample of each) → 24 outputs, `oDone` twice, second frame matches first.
- `reset` asserted mid-frame, then fresh frame → no residual outputs; fresh frame outputs match uniform-100 case.

Source files
------------

// File: rtl/filter_conv3x3_if.sv
// Pixel stream bundle for filter_conv3x3: padded RGB samples in, filtered RGB out.
// The master side drives samples and frame starts; the slave side is the filter.
interface filter_conv3x3_if;
    logic        newFrame;
    logic        iValid;
    logic [23:0] iData;
    logic        oValid;
    logic [23:0] oData;
    logic        oDone;

    modport master (output newFrame, iValid, iData, input  oValid, oData, oDone);
    modport slave  (input  newFrame, iValid, iData, output oValid, oData, oDone);
endinterface

// File: rtl/filter_conv3x3.sv
// Per-channel 3x3 signed-kernel convolution over a zero-padded raster RGB stream, fixed 3-edge latency.
// Define FILTER_CONV3X3_SAT_EN to clip each channel to [0,255]; otherwise the low 8 bits wrap.
module filter_conv3x3 #(
    parameter int          width  = 320,
    parameter int          height = 240,
    parameter logic [71:0] COEF   = {8'sd1, 8'sd2, 8'sd1, 8'sd2, 8'sd4, 8'sd2, 8'sd1, 8'sd2, 8'sd1},
    parameter int          SHIFT  = 4
) (
    input  logic            clk,
    input  logic            reset,
    filter_conv3x3_if.slave px
);
    localparam int W1   = width + 1;
    localparam int TAPS = 2 * W1 + 3;
    localparam int NPIX = width * height;
    localparam int CW   = $clog2(width + 1);
    localparam int RW   = $clog2(height + 2);
    localparam int OW   = $clog2(NPIX + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(width);
    localparam logic [RW-1:0] ROW_LAST = RW'(height + 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);
    localparam logic [OW-1:0] CNT_LAST = OW'(NPIX - 1);

    logic [23:0]        taps [TAPS];
    logic [CW-1:0]      colIn;
    logic [RW-1:0]      rowIn;
    logic [CW-1:0]      colEff;
    logic [RW-1:0]      rowEff;
    logic               v0, v1, v2;
    logic               nf0, nf1, nf2;
    logic signed [16:0] prod [3][9];
    logic signed [20:0] sum  [3];
    logic [OW-1:0]      oCnt;
    logic [OW-1:0]      cntBase;

    // Window tap k (row-major, 0 = top-left) sits this many samples behind the newest one.
    function automatic int tapIdx(input int k);
        return (2 - k / 3) * W1 + (2 - k % 3);
    endfunction

    function automatic logic signed [16:0] mulTap(input logic [7:0] pix, input logic [7:0] c);
        logic signed [16:0] a;
        logic signed [16:0] b;
        a = {9'd0, pix};
        b = {{9{c[7]}}, c};
        return a * b;
    endfunction

    function automatic logic signed [20:0] sum9(input int ch);
        logic signed [20:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++)
            acc = acc + {{4{prod[ch][k][16]}}, prod[ch][k]};
        return acc;
    endfunction

    function automatic logic [7:0] finish(input logic signed [20:0] s);
        logic signed [20:0] sh;
        sh = s >>> SHIFT;
`ifdef FILTER_CONV3X3_SAT_EN
        if (sh < 21'sd0)
            return 8'd0;
        if (sh > 21'sd255)
            return 8'd255;
`endif
        return sh[7:0];
    endfunction

    // A frame start overrides the running position so the same-cycle sample becomes index 0.
    always_comb begin
        colEff = px.newFrame ? '0 : colIn;
        rowEff = px.newFrame ? '0 : rowIn;
    end

    // The newFrame tag travels with the pipeline so the output count restarts in step with
    // the data, letting a back-to-back frame start without losing the previous frame's tail.
    assign cntBase = nf2 ? '0 : oCnt;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the delay line is explicitly cleared so a restart never convolves stale pixels.
            for (int i = 0; i < TAPS; i++)
                taps[i] <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 9; k++)
                    prod[ch][k] <= '0;
                sum[ch] <= '0;
            end
            colIn     <= '0;
            rowIn     <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            nf0       <= 1'b0;
            nf1       <= 1'b0;
            nf2       <= 1'b0;
            oCnt      <= '0;
            px.oValid <= 1'b0;
            px.oData  <= '0;
            px.oDone  <= 1'b0;
        end else begin
            nf0 <= px.newFrame;
            v0  <= px.iValid && (colEff != '0) && (rowEff >= ROW_MIN);
            if (px.iValid) begin
                taps[0] <= px.iData;
                for (int i = 1; i < TAPS; i++)
                    taps[i] <= taps[i-1];
                if (colEff == COL_LAST) begin
                    colIn <= '0;
                    rowIn <= (rowEff == ROW_LAST) ? '0 : rowEff + 1'b1;
                end else begin
                    colIn <= colEff + 1'b1;
                    rowIn <= rowEff;
                end
            end else begin
                colIn <= colEff;
                rowIn <= rowEff;
            end

            v1  <= v0;
            nf1 <= nf0;
            for (int ch = 0; ch < 3; ch++)
                for (int k = 0; k < 9; k++)
                    prod[ch][k] <= mulTap(taps[tapIdx(k)][23-8*ch -: 8], COEF[71-8*k -: 8]);

            v2  <= v1;
            nf2 <= nf1;
            for (int ch = 0; ch < 3; ch++)
                sum[ch] <= sum9(ch);

            px.oValid <= v2;
            px.oDone  <= v2 && (cntBase == CNT_LAST);
            if (v2) begin
                px.oData <= {finish(sum[0]), finish(sum[1]), finish(sum[2])};
                oCnt     <= (cntBase == CNT_LAST) ? '0 : cntBase + 1'b1;
            end else begin
                oCnt <= cntBase;
            end
        end
    end
endmodule
